// File: rtl/count_down_timer_pkg.sv
// Shared constants for the count-down timer: FSM state encodings and the default counter width.
// Optional feature macro: COUNT_AUTO_RELOAD_EN (periodic auto-reload from the captured start value).
package count_down_timer_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/down_counter_core.sv
// Count register for the timer: clear beats load beats decrement; never decrements below zero.
// is_one flags the terminal-count step so the FSM can move to DONE on the same edge COUNT reaches 0.
module down_counter_core
    import count_down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/count_down_timer.sv
// Loadable down-counter FSM (IDLE/RUN/DONE) feeding the downstream zero comparator.
// Define COUNT_AUTO_RELOAD_EN to restart from the captured start value after each expiry.
module count_down_timer
    import count_down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic             LOAD_RDY,
    input  logic             EN,
    input  logic             ABORT,
    output logic [WIDTH-1:0] COUNT,
    output logic             BUSY,
    output logic             DONE
);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_clear;
    logic             cnt_is_one;

`ifdef COUNT_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            reload <= '0;
        end else if ((state == ST_IDLE) && LOAD && !ABORT) begin
            reload <= LOAD_VAL;
        end
    end
`endif

    always_comb begin
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_load_val = LOAD_VAL;
        cnt_dec      = 1'b0;
        cnt_clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ABORT) begin
                    cnt_clear = 1'b1;
                end else if (LOAD) begin
                    cnt_load   = 1'b1;
                    next_state = (LOAD_VAL == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    cnt_clear  = 1'b1;
                    next_state = ST_IDLE;
                end else if (EN) begin
                    cnt_dec = 1'b1;
                    if (cnt_is_one) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (ABORT) begin
                    cnt_clear  = 1'b1;
                    next_state = ST_IDLE;
                end else begin
`ifdef COUNT_AUTO_RELOAD_EN
                    // A zero reload value parks the block in DONE until aborted.
                    if (reload != '0) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = reload;
                        next_state   = ST_RUN;
                    end
`else
                    next_state = ST_IDLE;
`endif
                end
            end
            default: begin
                cnt_clear  = 1'b1;
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    down_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .clear    (cnt_clear),
        .count    (COUNT),
        .is_one   (cnt_is_one)
    );

    assign LOAD_RDY = (state == ST_IDLE);
    assign BUSY     = (state == ST_RUN);
    assign DONE     = (state == ST_DONE);

endmodule

// File: tb/tb_count_down_timer.sv
// Self-checking bench for count_down_timer: directed scenarios plus random traffic against a behavioural model.
// Honours COUNT_AUTO_RELOAD_EN in the model so the same bench covers both builds.
module tb_count_down_timer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LOAD = 1'b0;
    logic [7:0] LOAD_VAL = '0;
    logic       LOAD_RDY;
    logic       EN = 1'b0;
    logic       ABORT = 1'b0;
    logic [7:0] COUNT;
    logic       BUSY;
    logic       DONE;

    int n_assert = 0;
    int n_fail = 0;

    // Model: remaining count plus "counting" and "expired" flags.
    int m_count = 0;
    bit m_counting = 0;
    bit m_expired = 0;
    int m_reload = 0;

    always #5 CLK = ~CLK;

    count_down_timer #(
        .WIDTH (8)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .LOAD_RDY (LOAD_RDY),
        .EN       (EN),
        .ABORT    (ABORT),
        .COUNT    (COUNT),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rn, input bit ld, input int lv, input bit en, input bit ab);
        if (!rn) begin
            m_count = 0; m_counting = 0; m_expired = 0; m_reload = 0;
        end else if (ab) begin
            m_count = 0; m_counting = 0; m_expired = 0;
        end else if (m_expired) begin
`ifdef COUNT_AUTO_RELOAD_EN
            if (m_reload != 0) begin
                m_count = m_reload; m_counting = 1; m_expired = 0;
            end
`else
            m_expired = 0;
`endif
        end else if (m_counting) begin
            if (en) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_counting = 0; m_expired = 1;
                end
            end
        end else if (ld) begin
            m_count = lv; m_reload = lv;
            if (lv == 0) m_expired = 1;
            else m_counting = 1;
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".count"}, 32'(COUNT), 32'(m_count));
        cmp({tag, ".busy"}, 32'(BUSY), 32'(m_counting));
        cmp({tag, ".done"}, 32'(DONE), 32'(m_expired));
        cmp({tag, ".load_rdy"}, 32'(LOAD_RDY), 32'(!m_counting && !m_expired));
    endtask

    task automatic step(input string tag, input bit rn, input bit ld, input logic [7:0] lv,
                        input bit en, input bit ab);
        RST_N = rn; LOAD = ld; LOAD_VAL = lv; EN = en; ABORT = ab;
        @(posedge CLK);
        model_edge(rn, ld, int'(lv), en, ab);
        #1;
        check_model(tag);
    endtask

    initial begin
        int waited;
        int done_at;
        bit seen;

        // Reset held two cycles with LOAD asserted
        step("rst0", 0, 1, 8'd9, 1, 0);
        step("rst1", 0, 1, 8'd9, 1, 0);
        cmp("rst.count", 32'(COUNT), 32'd0);
        cmp("rst.load_rdy", 32'(LOAD_RDY), 32'd1);
        cmp("rst.busy", 32'(BUSY), 32'd0);
        cmp("rst.done", 32'(DONE), 32'd0);

        // Load 5 with EN high: 5,4,3,2,1,0 then DONE one cycle
        step("ld5", 1, 1, 8'd5, 1, 0);
        cmp("ld5.count0", 32'(COUNT), 32'd5);
        for (int k = 1; k <= 5; k++) begin
            step("ld5.run", 1, 0, 8'd77, 1, 0);
            cmp("ld5.countk", 32'(COUNT), 32'(5 - k));
        end
        cmp("ld5.done", 32'(DONE), 32'd1);
        step("ld5.after", 1, 0, 8'd0, 1, 0);
`ifndef COUNT_AUTO_RELOAD_EN
        cmp("ld5.idle_rdy", 32'(LOAD_RDY), 32'd1);
        cmp("ld5.idle_done", 32'(DONE), 32'd0);
`endif

        // Load 0: straight to DONE, then IDLE
        step("ld0", 1, 1, 8'd0, 1, 0);
        cmp("ld0.done", 32'(DONE), 32'd1);
        cmp("ld0.busy", 32'(BUSY), 32'd0);
        step("ld0.after", 1, 0, 8'd0, 1, 1);
        cmp("ld0.idle", 32'(LOAD_RDY), 32'd1);

        // Load 4, pause 3 cycles at COUNT=2: DONE seen 7 edges after load
        step("ld4", 1, 1, 8'd4, 1, 0);
        step("ld4.r1", 1, 0, 8'd0, 1, 0);
        step("ld4.r2", 1, 0, 8'd0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step("ld4.pause", 1, 1, 8'd33, 0, 0);
            cmp("ld4.hold", 32'(COUNT), 32'd2);
        end
        done_at = 0;
        seen = 0;
        for (int k = 6; k <= 20 && !seen; k++) begin
            step("ld4.run", 1, 0, 8'd0, 1, 0);
            if (DONE) begin
                seen = 1;
                done_at = k;
            end
        end
        cmp("ld4.done_edge", 32'(done_at), 32'd7);
        step("ld4.clr", 1, 0, 8'd0, 0, 1);

        // Load 10, abort once COUNT reaches 6
        step("ld10", 1, 1, 8'd10, 1, 0);
        waited = 0;
        while (m_count != 6 && waited < 20) begin
            step("ld10.run", 1, 0, 8'd0, 1, 0);
            waited++;
        end
        cmp("ld10.reach6", 32'(COUNT), 32'd6);
        step("ld10.abort", 1, 1, 8'd0, 1, 1);
        cmp("abort.count", 32'(COUNT), 32'd0);
        cmp("abort.busy", 32'(BUSY), 32'd0);
        step("abort.after", 1, 0, 8'd0, 1, 0);
        cmp("abort.nodone", 32'(DONE), 32'd0);

        // LOAD and ABORT on the same edge in IDLE: load dropped
        step("ldab", 1, 1, 8'd9, 1, 1);
        cmp("ldab.count", 32'(COUNT), 32'd0);
        cmp("ldab.rdy", 32'(LOAD_RDY), 32'd1);

        // Reset in the middle of a run
        step("ld7", 1, 1, 8'd7, 1, 0);
        step("ld7.r", 1, 0, 8'd0, 1, 0);
        step("ld7.rst", 0, 0, 8'd0, 1, 0);
        cmp("midrst.count", 32'(COUNT), 32'd0);
        cmp("midrst.rdy", 32'(LOAD_RDY), 32'd1);

        // Maximum load value counts down from 255
        step("ld255", 1, 1, 8'd255, 1, 0);
        step("ld255.r", 1, 0, 8'd0, 1, 0);
        cmp("ld255.count", 32'(COUNT), 32'd254);
        step("ld255.ab", 1, 0, 8'd0, 0, 1);

`ifdef COUNT_AUTO_RELOAD_EN
        // Auto-reload: load 3 gives DONE every 4 cycles
        step("ar3", 1, 1, 8'd3, 1, 0);
        done_at = -1;
        for (int k = 1; k <= 16; k++) begin
            step("ar3.run", 1, 0, 8'd0, 1, 0);
            if (DONE) begin
                if (done_at >= 0) cmp("ar3.period", 32'(k - done_at), 32'd4);
                done_at = k;
            end
        end
        step("ar3.abort", 1, 0, 8'd0, 1, 1);
        cmp("ar3.idle", 32'(LOAD_RDY), 32'd1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] lv;
            lv = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
            step("rand", $urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, lv,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
